// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests words from instruction memory, holds them for
// decode, and stops on an unsupported opcode or a memory ack timeout.
//
// state | meaning
// IDLE  | one quiet cycle after reset, then start fetching
// REQ   | imem_req high at pc, waiting for imem_ack (bounded by TIMEOUT)
// HOLD  | instruction valid for downstream, waiting for stall to drop
// HALT  | illegal opcode or memory timeout, parked until reset
module instr_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        illegal,
  output logic        imem_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_HALT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        illegal_q, illegal_d;
  logic        err_q, err_d;

  function automatic logic op_legal(input logic [5:0] opc);
    case (opc)
      6'b000000, 6'b100110, 6'b101011,
      6'b001000, 6'b001101, 6'b001100: op_legal = 1'b1;
      default:                         op_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RESET;
      instr_q   <= '0;
      pc_out_q  <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // An ack in the last allowed cycle still counts as a good fetch.
        if (imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          pc_d     = pc_q + 32'd4;
          cnt_d    = '0;
          if (op_legal(imem_rdata[31:26])) begin
            state_d = S_HOLD;
          end else begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: if (!stall) state_d = S_REQ;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = imem_req ? pc_q : 32'h0;
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign imm         = instr_q[15:0];
  assign pc_out      = pc_out_q;
  assign illegal     = illegal_q;
  assign imem_err    = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: u0 default parameters, u1 TIMEOUT=4,
// u2 PC_RESET=FFFF_FFFC. Inputs change and outputs are checked on falling edges.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n [3];
  logic        stall [3];
  logic        ack   [3];
  logic [31:0] rdata [3];
  logic        req   [3];
  logic [31:0] addr  [3];
  logic [31:0] instr [3];
  logic [5:0]  op    [3];
  logic [4:0]  rs    [3];
  logic [4:0]  rt    [3];
  logic [4:0]  rd    [3];
  logic [15:0] imm   [3];
  logic [31:0] pc_out[3];
  logic        valid [3];
  logic        ill   [3];
  logic        err   [3];

  int checks = 0;
  int failures = 0;

  instr_fetch u0 (
    .clk(clk), .rst_n(rst_n[0]), .stall(stall[0]), .imem_req(req[0]), .imem_addr(addr[0]),
    .imem_ack(ack[0]), .imem_rdata(rdata[0]), .instr(instr[0]), .op(op[0]), .rs(rs[0]),
    .rt(rt[0]), .rd(rd[0]), .imm(imm[0]), .pc_out(pc_out[0]), .instr_valid(valid[0]),
    .illegal(ill[0]), .imem_err(err[0]));

  instr_fetch #(.TIMEOUT(4)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .stall(stall[1]), .imem_req(req[1]), .imem_addr(addr[1]),
    .imem_ack(ack[1]), .imem_rdata(rdata[1]), .instr(instr[1]), .op(op[1]), .rs(rs[1]),
    .rt(rt[1]), .rd(rd[1]), .imm(imm[1]), .pc_out(pc_out[1]), .instr_valid(valid[1]),
    .illegal(ill[1]), .imem_err(err[1]));

  instr_fetch #(.PC_RESET(32'hFFFF_FFFC)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .stall(stall[2]), .imem_req(req[2]), .imem_addr(addr[2]),
    .imem_ack(ack[2]), .imem_rdata(rdata[2]), .instr(instr[2]), .op(op[2]), .rs(rs[2]),
    .rt(rt[2]), .rd(rd[2]), .imm(imm[2]), .pc_out(pc_out[2]), .instr_valid(valid[2]),
    .illegal(ill[2]), .imem_err(err[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves instance k in REQ at its reset pc, checked at a falling edge.
  task automatic do_reset(input int k);
    rst_n[k] = 1'b0; ack[k] = 1'b0; stall[k] = 1'b0;
    tick();
    rst_n[k] = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    ack[0] = 1'b1; rdata[0] = 32'h2008_0005;
    tick(); tick();
    checks++; if (req[0] !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", req[0]); end
    checks++; if (valid[0] !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", valid[0]); end
    checks++; if (instr[0] !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr[0]); end
    checks++; if (pc_out[0] !== 32'h0) begin failures++; $display("FAIL rst_pc_out got=%h exp=0", pc_out[0]); end
    checks++; if ({ill[0], err[0]} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {ill[0], err[0]}); end
    ack[0] = 1'b0; rst_n[0] = 1'b1;
    #1;
    checks++; if (req[0] !== 1'b0) begin failures++; $display("FAIL idle_req got=%0b exp=0", req[0]); end
    tick();
    checks++; if (req[0] !== 1'b1 || addr[0] !== 32'h0) begin failures++; $display("FAIL first_req got=%0b/%h exp=1/0", req[0], addr[0]); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      checks++; if (req[0] !== 1'b1 || addr[0] !== 32'(4 * i) || valid[0] !== 1'b0) begin
        failures++; $display("FAIL stream_req%0d got=%0b/%h/%0b exp=1/%h/0", i, req[0], addr[0], valid[0], 4 * i); end
      ack[0] = 1'b1; rdata[0] = 32'h2008_0005;
      tick();
      ack[0] = 1'b0;
      checks++; if (valid[0] !== 1'b1 || req[0] !== 1'b0 || addr[0] !== 32'h0) begin
        failures++; $display("FAIL stream_hold%0d got=%0b/%0b/%h exp=1/0/0", i, valid[0], req[0], addr[0]); end
      checks++; if (op[0] !== 6'b001000 || rt[0] !== 5'd8 || imm[0] !== 16'd5 || pc_out[0] !== 32'(4 * i)) begin
        failures++; $display("FAIL stream_fields%0d got=%b/%0d/%0d/%h exp=001000/8/5/%h", i, op[0], rt[0], imm[0], pc_out[0], 4 * i); end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset(0);
    ack[0] = 1'b1; rdata[0] = 32'h012A_4020; stall[0] = 1'b1;
    tick();
    rdata[0] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      checks++; if (valid[0] !== 1'b1 || instr[0] !== 32'h012A_4020 || req[0] !== 1'b0 || addr[0] !== 32'h0) begin
        failures++; $display("FAIL stall_hold%0d got=%0b/%h/%0b/%h exp=1/012a4020/0/0", i, valid[0], instr[0], req[0], addr[0]); end
      if (i == 4) begin stall[0] = 1'b0; ack[0] = 1'b0; end
      tick();
    end
    checks++; if (rs[0] !== 5'd9 || rt[0] !== 5'd10 || rd[0] !== 5'd8 || imm[0] !== 16'h4020) begin
      failures++; $display("FAIL stall_fields got=%0d/%0d/%0d/%h exp=9/10/8/4020", rs[0], rt[0], rd[0], imm[0]); end
    checks++; if (req[0] !== 1'b1 || addr[0] !== 32'h4) begin
      failures++; $display("FAIL stall_next got=%0b/%h exp=1/4", req[0], addr[0]); end
  endtask

  task automatic test_illegal();
    logic [31:0] words [3];
    int reqs;
    words[0] = 32'h9800_0004; words[1] = 32'hAC00_0008; words[2] = 32'hFC00_0000;
    do_reset(0);
    for (int i = 0; i < 3; i++) begin
      ack[0] = 1'b1; rdata[0] = words[i];
      tick();
      ack[0] = 1'b0;
      if (i < 2) tick();
    end
    checks++; if (ill[0] !== 1'b1 || pc_out[0] !== 32'h8 || instr[0] !== 32'hFC00_0000) begin
      failures++; $display("FAIL illegal_hold got=%0b/%h/%h exp=1/8/fc000000", ill[0], pc_out[0], instr[0]); end
    reqs = 0;
    ack[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (req[0] !== 1'b0 || valid[0] !== 1'b0) reqs++;
      tick();
    end
    ack[0] = 1'b0;
    checks++; if (reqs !== 0 || ill[0] !== 1'b1 || err[0] !== 1'b0) begin
      failures++; $display("FAIL illegal_halt got=%0d/%0b/%0b exp=0/1/0", reqs, ill[0], err[0]); end
  endtask

  task automatic test_opcodes();
    logic [31:0] words [3];
    words[0] = 32'h3400_00FF; words[1] = 32'h3000_0001; words[2] = 32'h8C00_0000;
    do_reset(0);
    for (int i = 0; i < 3; i++) begin
      ack[0] = 1'b1; rdata[0] = words[i];
      tick();
      ack[0] = 1'b0;
      checks++; if (valid[0] !== (i < 2) || ill[0] !== (i == 2)) begin
        failures++; $display("FAIL opcode%0d got=%0b/%0b exp=%0b/%0b", i, valid[0], ill[0], i < 2, i == 2); end
      if (i < 2) tick();
    end
  endtask

  task automatic test_timeout();
    int hi;
    do_reset(1);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (req[1] === 1'b1) hi++;
      tick();
    end
    checks++; if (hi !== 4) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=4", hi); end
    checks++; if (err[1] !== 1'b1 || valid[1] !== 1'b0 || ill[1] !== 1'b0) begin
      failures++; $display("FAIL timeout_err got=%0b/%0b/%0b exp=1/0/0", err[1], valid[1], ill[1]); end
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (req[1] !== 1'b1 || err[1] !== 1'b0) begin
        failures++; $display("FAIL late_ack_req%0d got=%0b/%0b exp=1/0", i, req[1], err[1]); end
      if (i == 3) begin ack[1] = 1'b1; rdata[1] = 32'h2008_0005; end
      tick();
    end
    ack[1] = 1'b0;
    checks++; if (valid[1] !== 1'b1 || err[1] !== 1'b0 || pc_out[1] !== 32'h0) begin
      failures++; $display("FAIL late_ack_hold got=%0b/%0b/%h exp=1/0/0", valid[1], err[1], pc_out[1]); end
  endtask

  task automatic test_wrap();
    do_reset(2);
    checks++; if (addr[2] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", addr[2]); end
    ack[2] = 1'b1; rdata[2] = 32'h0000_0020;
    tick();
    ack[2] = 1'b0;
    checks++; if (valid[2] !== 1'b1 || pc_out[2] !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_hold0 got=%0b/%h exp=1/fffffffc", valid[2], pc_out[2]); end
    tick();
    checks++; if (req[2] !== 1'b1 || addr[2] !== 32'h0) begin failures++; $display("FAIL wrap_addr1 got=%0b/%h exp=1/0", req[2], addr[2]); end
    ack[2] = 1'b1;
    tick();
    ack[2] = 1'b0;
    checks++; if (valid[2] !== 1'b1 || pc_out[2] !== 32'h0 || ill[2] !== 1'b0) begin
      failures++; $display("FAIL wrap_hold1 got=%0b/%h/%0b exp=1/0/0", valid[2], pc_out[2], ill[2]); end
  endtask

  task automatic test_reset_in_hold();
    do_reset(0);
    ack[0] = 1'b1; rdata[0] = 32'h2008_0005; stall[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    tick();
    checks++; if (valid[0] !== 1'b1) begin failures++; $display("FAIL rih_pre got=%0b exp=1", valid[0]); end
    #2 rst_n[0] = 1'b0; ack[0] = 1'b1; rdata[0] = 32'h3000_1234;
    #1;
    checks++; if (valid[0] !== 1'b0 || instr[0] !== 32'h0 || pc_out[0] !== 32'h0 || req[0] !== 1'b0) begin
      failures++; $display("FAIL rih_async got=%0b/%h/%h/%0b exp=0/0/0/0", valid[0], instr[0], pc_out[0], req[0]); end
    tick(); tick();
    checks++; if (instr[0] !== 32'h0 || valid[0] !== 1'b0) begin
      failures++; $display("FAIL rih_stray_ack got=%h/%0b exp=0/0", instr[0], valid[0]); end
    ack[0] = 1'b0; stall[0] = 1'b0; rst_n[0] = 1'b1;
    tick();
    checks++; if (req[0] !== 1'b1 || addr[0] !== 32'h0) begin
      failures++; $display("FAIL rih_restart got=%0b/%h exp=1/0", req[0], addr[0]); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; stall[k] = 1'b0; ack[k] = 1'b0; rdata[k] = 32'h0;
    end
    test_reset();
    test_stream();
    test_stall();
    test_illegal();
    test_opcodes();
    test_timeout();
    test_wrap();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
